// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing a single-port synchronous RAM: core (r0) has fixed
// priority, a starvation counter bounds the loader's (r1) wait, read data returns to its owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_r0_valid,
  input  logic                    i_r1_valid,
  output logic                    o_r0_ready,
  output logic                    o_r1_ready,
  input  logic                    i_r0_we,
  input  logic                    i_r1_we,
  input  logic [ADDR_WIDTH-1:0]   i_r0_addr,
  input  logic [ADDR_WIDTH-1:0]   i_r1_addr,
  input  logic [DATA_WIDTH-1:0]   i_r0_wdata,
  input  logic [DATA_WIDTH-1:0]   i_r1_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_r0_be,
  input  logic [DATA_WIDTH/8-1:0] i_r1_be,
  output logic                    o_r0_rvalid,
  output logic                    o_r1_rvalid,
  output logic [DATA_WIDTH-1:0]   o_r0_rdata,
  output logic [DATA_WIDTH-1:0]   o_r1_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             force_r1_s, gnt0_s, gnt1_s;

  assign force_r1_s = (wait_cnt_q == MAX_CNT);

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!i_arst_n) begin
      gnt0_s = 1'b0;
    end else if (force_r1_s && i_r1_valid) begin
      gnt1_s = 1'b1;
    end else if (i_r0_valid) begin
      gnt0_s = 1'b1;
    end else if (i_r1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (gnt0_s) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_r0_we;
      o_mem_addr  = i_r0_addr;
      o_mem_wdata = i_r0_wdata;
      o_mem_be    = i_r0_we ? i_r0_be : {BE_W{1'b0}};
    end else if (gnt1_s) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_r1_we;
      o_mem_addr  = i_r1_addr;
      o_mem_wdata = i_r1_wdata;
      o_mem_be    = i_r1_we ? i_r1_be : {BE_W{1'b0}};
    end else begin
      o_mem_en    = 1'b0;
    end
  end

  // Starvation counter only runs while the loader is actually being denied.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_r1_valid || gnt1_s) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == MAX_CNT) begin
      wait_cnt_d = MAX_CNT;
    end else begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    rd_pend_d  = (gnt0_s && !i_r0_we) || (gnt1_s && !i_r1_we);
    rd_owner_d = gnt1_s;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign o_r0_ready  = gnt0_s;
  assign o_r1_ready  = gnt1_s;
  assign o_r0_rvalid = rd_pend_q && !rd_owner_q;
  assign o_r1_rvalid = rd_pend_q && rd_owner_q;
  assign o_r0_rdata  = o_r0_rvalid ? i_mem_rdata : {DATA_WIDTH{1'b0}};
  assign o_r1_rdata  = o_r1_rvalid ? i_mem_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a write-first RAM model plus a
// behavioural reference (grant rules, denied-cycle count, shadow memory, expected responses).
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          r0_v = 1'b0, r1_v = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic [BW-1:0] r0_be = '0, r1_be = '0;
  logic          r0_rdy, r1_rdy, r0_rv, r1_rv;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ram [0:1023] = '{default: '0};

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_r0_valid(r0_v), .i_r1_valid(r1_v),
    .o_r0_ready(r0_rdy), .o_r1_ready(r1_rdy),
    .i_r0_we(r0_we), .i_r1_we(r1_we),
    .i_r0_addr(r0_addr), .i_r1_addr(r1_addr),
    .i_r0_wdata(r0_wdata), .i_r1_wdata(r1_wdata),
    .i_r0_be(r0_be), .i_r1_be(r1_be),
    .o_r0_rvalid(r0_rv), .o_r1_rvalid(r1_rv),
    .o_r0_rdata(r0_rdata), .o_r1_rdata(r1_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  // Write-first single-port RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_be);
        mem_rdata     <= merge(ram[mem_addr], mem_wdata, mem_be);
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int            checks = 0, errors = 0;
  int            denied = 0;
  bit            pend = 1'b0, owner = 1'b0, eg0, eg1, obs_rdy1;
  logic [DW-1:0] pdata = '0, last_rd0 = '0, last_rd1 = '0;
  logic [DW-1:0] shadow [0:1023] = '{default: '0};

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: check combinational/response outputs, then advance the reference model.
  task automatic step();
    logic          gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gwd;
    logic [BW-1:0] gbe;
    #1;
    if (!rst_n) begin
      denied = 0; pend = 1'b0; owner = 1'b0;
    end
    eg0 = 1'b0; eg1 = 1'b0;
    if (rst_n) begin
      if (r1_v && denied >= MAXW) eg1 = 1'b1;
      else if (r0_v) eg0 = 1'b1;
      else if (r1_v) eg1 = 1'b1;
    end
    gwe   = eg0 ? r0_we : (eg1 ? r1_we : 1'b0);
    gaddr = eg0 ? r0_addr : (eg1 ? r1_addr : '0);
    gwd   = eg0 ? r0_wdata : r1_wdata;
    gbe   = eg0 ? r0_be : r1_be;
    check_val("r0_ready", 32'(r0_rdy), 32'(eg0));
    check_val("r1_ready", 32'(r1_rdy), 32'(eg1));
    check_val("mem_en", 32'(mem_en), 32'(eg0 | eg1));
    check_val("mem_we", 32'(mem_we), 32'(gwe));
    check_val("mem_addr", 32'(mem_addr), 32'(gaddr));
    check_val("mem_be", 32'(mem_be), gwe ? 32'(gbe) : 32'd0);
    if (gwe) check_val("mem_wdata", mem_wdata, gwd);
    if (!(eg0 | eg1)) check_val("mem_wdata_idle", mem_wdata, 32'd0);
    check_val("r0_rvalid", 32'(r0_rv), 32'(pend && !owner));
    check_val("r1_rvalid", 32'(r1_rv), 32'(pend && owner));
    check_val("r0_rdata", r0_rdata, (pend && !owner) ? pdata : 32'd0);
    check_val("r1_rdata", r1_rdata, (pend && owner) ? pdata : 32'd0);
    if (r0_rv) last_rd0 = r0_rdata;
    if (r1_rv) last_rd1 = r1_rdata;
    obs_rdy1 = r1_rdy;
    @(posedge clk);
    if (rst_n) begin
      pend = 1'b0;
      if (eg0 || eg1) begin
        if (gwe) shadow[gaddr] = merge(shadow[gaddr], gwd, gbe);
        else begin
          pend = 1'b1; owner = eg1; pdata = shadow[gaddr];
        end
      end
      if (r1_v && !eg1) denied = (denied + 1 > MAXW) ? MAXW : denied + 1;
      else denied = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_r0(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    r0_v = v; r0_we = we; r0_addr = a; r0_wdata = d; r0_be = be;
  endtask

  task automatic set_r1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    r1_v = v; r1_we = we; r1_addr = a; r1_wdata = d; r1_be = be;
  endtask

  // Issue one request on a port with the other idle, then one more cycle for any response.
  task automatic xfer(input bit port, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
    int n;
    set_r0(1'b0, 1'b0, '0, '0, '0);
    set_r1(1'b0, 1'b0, '0, '0, '0);
    if (port) set_r1(1'b1, we, a, d, be);
    else set_r0(1'b1, we, a, d, be);
    n = 0;
    do begin
      step(); n++;
    end while (!(port ? eg1 : eg0) && n < 20);
    check_val("xfer_granted", 32'(n), 32'd1);
    r0_v = 1'b0; r1_v = 1'b0;
    step();
  endtask

  // r0 busy every cycle; count r1's valid cycles until it is granted.
  task automatic starve_run(input string tag);
    int n;
    bit got;
    set_r0(1'b1, 1'b0, 10'd7, '0, '0);
    set_r1(1'b1, 1'b0, 10'd8, '0, '0);
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      step(); n++;
      if (obs_rdy1) got = 1'b1;
    end
    check_val(tag, 32'(n), 32'(MAXW + 1));
    r1_v = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // Reset held with both requesters active
    set_r0(1'b1, 1'b0, 10'd1, '0, '0);
    set_r1(1'b1, 1'b0, 10'd2, '0, '0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_val("first_grant_r0", 32'(r0_rdy), 32'd1);
    r0_v = 1'b0; r1_v = 1'b0;
    step();

    // Loader preload then poll
    xfer(1'b1, 1'b1, 10'd321, 32'h15, 4'hF);
    xfer(1'b1, 1'b1, 10'd320, 32'h1, 4'hF);
    last_rd1 = 32'hFFFF_FFFF;
    xfer(1'b1, 1'b0, 10'd320, '0, '0);
    check_val("poll_flag", last_rd1, 32'h1);

    // Priority and starvation bound, twice to show the counter cleared
    starve_run("starve_slot_a");
    step();
    starve_run("starve_slot_b");
    // r1 drops valid mid-wait: a fresh full wait is required
    set_r1(1'b1, 1'b0, 10'd9, '0, '0);
    step(); step(); step();
    r1_v = 1'b0;
    step();
    starve_run("starve_after_drop");
    r0_v = 1'b0;
    step();

    // Response routing without cross-talk
    xfer(1'b1, 1'b1, 10'd5, 32'hAAAA, 4'hF);
    xfer(1'b1, 1'b1, 10'd6, 32'h5555, 4'hF);
    set_r0(1'b1, 1'b0, 10'd5, '0, '0);
    step();
    set_r0(1'b0, 1'b0, '0, '0, '0);
    set_r1(1'b1, 1'b0, 10'd6, '0, '0);
    step();
    check_val("route_r0", last_rd0, 32'hAAAA);
    r1_v = 1'b0;
    step();
    check_val("route_r1", last_rd1, 32'h5555);

    // Byte enables
    xfer(1'b0, 1'b1, 10'd40, 32'h0, 4'hF);
    xfer(1'b0, 1'b1, 10'd40, 32'hDEADBEEF, 4'b0011);
    xfer(1'b0, 1'b0, 10'd40, '0, '0);
    check_val("byte_enable", last_rd0, 32'h0000BEEF);

    // Reset in the cycle after a read accept drops the response
    set_r0(1'b1, 1'b0, 10'd5, '0, '0);
    step();
    r0_v = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!r0_v && $urandom_range(0, 3) != 0)
        set_r0(1'b1, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 10'd320 : 10'($urandom_range(0, 15)),
               $urandom, 4'($urandom_range(0, 15)));
      if (!r1_v && $urandom_range(0, 2) == 0)
        set_r1(1'b1, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 10'd321 : 10'($urandom_range(0, 15)),
               $urandom, 4'($urandom_range(0, 15)));
      else if (r1_v && $urandom_range(0, 15) == 0)
        r1_v = 1'b0;
      step();
      if (eg0) r0_v = 1'b0;
      if (eg1) r1_v = 1'b0;
    end
    r0_v = 1'b0; r1_v = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
